// File: rtl/score_tracker.sv
// score_tracker: game-score bookkeeping for the Genius (Simon) game.
// Counts completed rounds, keeps the session high score and drives the value
// shown on the two-digit score display.
//
// Parameters:
//   MAX_SCORE      saturation ceiling for score (<= 64, the decoder's range)
//   TOGGLE_CYCLES  cycles per display phase while in OVER (>= 1)
// Ports:
//   clk         system clock, rising edge
//   rst_n       synchronous active-low reset
//   new_game    one-cycle pulse, start/restart a game
//   round_ok    one-cycle pulse, sequence reproduced correctly
//   game_over   one-cycle pulse, player failed
//   score       current game score, 0..MAX_SCORE
//   high_score  best score since reset
//   new_record  last finished game set a new high score
//   disp_score  value sent to the 7-segment decoder
//   playing     high while in PLAY
// All outputs are registered.
module score_tracker #(
    parameter int unsigned MAX_SCORE     = 64,
    parameter int unsigned TOGGLE_CYCLES = 25_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       new_game,
    input  logic       round_ok,
    input  logic       game_over,
    output logic [6:0] score,
    output logic [6:0] high_score,
    output logic       new_record,
    output logic [6:0] disp_score,
    output logic       playing
);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StPlay = 2'b01,
        StOver = 2'b10
    } state_e;

    localparam logic [6:0]  MaxScore = 7'(MAX_SCORE);
    localparam int unsigned CntW     = (TOGGLE_CYCLES > 1) ? $clog2(TOGGLE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TOGGLE_CYCLES - 1);

    state_e          state_q, state_d;
    logic [6:0]      score_q, score_d;
    logic [6:0]      high_q, high_d;
    logic            rec_q, rec_d;
    logic [6:0]      disp_q, disp_d;
    logic            playing_q, playing_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            phase_q, phase_d;
    logic [6:0]      score_sat;

    // Compare before the add so the increment can never wrap.
    assign score_sat = (round_ok && (score_q < MaxScore)) ? score_q + 7'd1 : score_q;

    always_comb begin
        state_d = state_q;
        score_d = score_q;
        high_d  = high_q;
        rec_d   = rec_q;
        // Counter and phase stay cleared everywhere except while remaining in OVER.
        cnt_d   = '0;
        phase_d = 1'b0;

        case (state_q)
            StIdle: begin
                if (new_game) begin
                    state_d = StPlay;
                    score_d = 7'd0;
                    rec_d   = 1'b0;
                end
            end
            StPlay: begin
                if (new_game) begin
                    score_d = 7'd0;
                    rec_d   = 1'b0;
                end else begin
                    score_d = score_sat;
                    if (game_over) begin
                        state_d = StOver;
                        // Tie is not a record.
                        if (score_sat > high_q) begin
                            high_d = score_sat;
                            rec_d  = 1'b1;
                        end else begin
                            rec_d = 1'b0;
                        end
                    end
                end
            end
            StOver: begin
                if (new_game) begin
                    state_d = StPlay;
                    score_d = 7'd0;
                    rec_d   = 1'b0;
                end else if (cnt_q == CntLast) begin
                    cnt_d   = '0;
                    phase_d = ~phase_q;
                end else begin
                    cnt_d   = cnt_q + CntW'(1);
                    phase_d = phase_q;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Display follows the next state so it lines up with the other registered outputs.
        case (state_d)
            StPlay:  disp_d = score_d;
            StOver:  disp_d = phase_d ? high_d : score_d;
            default: disp_d = high_d;
        endcase
        playing_d = (state_d == StPlay);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            score_q   <= 7'd0;
            high_q    <= 7'd0;
            rec_q     <= 1'b0;
            disp_q    <= 7'd0;
            playing_q <= 1'b0;
            cnt_q     <= '0;
            phase_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            score_q   <= score_d;
            high_q    <= high_d;
            rec_q     <= rec_d;
            disp_q    <= disp_d;
            playing_q <= playing_d;
            cnt_q     <= cnt_d;
            phase_q   <= phase_d;
        end
    end

    assign score      = score_q;
    assign high_score = high_q;
    assign new_record = rec_q;
    assign disp_score = disp_q;
    assign playing    = playing_q;

endmodule

// File: tb/tb_score_tracker.sv
// tb_score_tracker: directed test-plan scenarios followed by randomized
// event traffic, all checked against a behavioural model of the score rules.
module tb_score_tracker;

    localparam int T   = 4;
    localparam int MAX = 64;

    logic       clk;
    logic       rst_n;
    logic       new_game;
    logic       round_ok;
    logic       game_over;
    logic [6:0] score;
    logic [6:0] high_score;
    logic       new_record;
    logic [6:0] disp_score;
    logic       playing;

    int checks   = 0;
    int failures = 0;

    // Reference model: mode 0=idle, 1=play, 2=over; over_cyc counts cycles since OVER entry.
    int m_mode  = 0;
    int m_score = 0;
    int m_high  = 0;
    int m_rec   = 0;
    int m_over  = 0;

    score_tracker #(
        .MAX_SCORE    (MAX),
        .TOGGLE_CYCLES(T)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .new_game  (new_game),
        .round_ok  (round_ok),
        .game_over (game_over),
        .score     (score),
        .high_score(high_score),
        .new_record(new_record),
        .disp_score(disp_score),
        .playing   (playing)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int model_disp();
        if (m_mode == 1) return m_score;
        if (m_mode == 2) return (((m_over / T) % 2) == 1) ? m_high : m_score;
        return m_high;
    endfunction

    task automatic model_update(input bit ng, input bit ok, input bit go, input bit rn);
        if (!rn) begin
            m_mode = 0; m_score = 0; m_high = 0; m_rec = 0; m_over = 0;
        end else if (m_mode == 1) begin
            if (ng) begin
                m_score = 0; m_rec = 0;
            end else begin
                if (ok && m_score < MAX) m_score++;
                if (go) begin
                    m_mode = 2;
                    m_over = 0;
                    m_rec  = (m_score > m_high) ? 1 : 0;
                    if (m_score > m_high) m_high = m_score;
                end
            end
        end else if (ng) begin
            m_mode = 1; m_score = 0; m_rec = 0;
        end else if (m_mode == 2) begin
            m_over++;
        end
    endtask

    // One clock: drive at negedge, sample 1 ns after posedge, compare to model.
    task automatic step(input bit ng, input bit ok, input bit go, input bit rn);
        @(negedge clk);
        new_game  = ng;
        round_ok  = ok;
        game_over = go;
        rst_n     = rn;
        @(posedge clk);
        #1;
        model_update(ng, ok, go, rn);
        check_eq("score", 32'(score), 32'(m_score));
        check_eq("high_score", 32'(high_score), 32'(m_high));
        check_eq("new_record", 32'(new_record), 32'(m_rec));
        check_eq("disp_score", 32'(disp_score), 32'(model_disp()));
        check_eq("playing", 32'(playing), (m_mode == 1) ? 32'd1 : 32'd0);
    endtask

    task automatic oks(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
    endtask

    initial begin
        int exp_seq[9];
        exp_seq = '{2, 2, 2, 2, 9, 9, 9, 9, 2};
        rst_n = 1'b0; new_game = 1'b0; round_ok = 1'b0; game_over = 1'b0;

        // Reset state and basic game.
        step(0, 0, 0, 0);
        check_eq("rst_disp", 32'(disp_score), 32'd0);
        step(0, 1, 1, 1);  // ignored in IDLE
        step(1, 0, 0, 1);
        check_eq("ng_playing", 32'(playing), 32'd1);
        oks(5);
        step(0, 0, 1, 1);
        check_eq("tp1_score", 32'(score), 32'd5);
        check_eq("tp1_high", 32'(high_score), 32'd5);
        check_eq("tp1_rec", 32'(new_record), 32'd1);
        check_eq("tp1_playing", 32'(playing), 32'd0);

        // Saturation.
        step(0, 0, 0, 0);
        step(1, 0, 0, 1);
        oks(70);
        check_eq("sat_score", 32'(score), 32'd64);
        step(0, 0, 1, 1);
        check_eq("sat_high", 32'(high_score), 32'd64);

        // Simultaneous round_ok + game_over, then a tie.
        step(0, 0, 0, 0);
        step(1, 0, 0, 1); oks(3); step(0, 0, 1, 1);
        step(1, 0, 0, 1); oks(3); step(0, 1, 1, 1);
        check_eq("sim_score", 32'(score), 32'd4);
        check_eq("sim_high", 32'(high_score), 32'd4);
        check_eq("sim_rec", 32'(new_record), 32'd1);
        step(1, 0, 0, 1);
        check_eq("ng_clr_rec", 32'(new_record), 32'd0);
        oks(4); step(0, 0, 1, 1);
        check_eq("tie_high", 32'(high_score), 32'd4);
        check_eq("tie_rec", 32'(new_record), 32'd0);

        // OVER alternation with score 2, high 9.
        step(0, 0, 0, 0);
        step(1, 0, 0, 1); oks(9); step(0, 0, 1, 1);
        step(1, 0, 0, 1); oks(2); step(0, 0, 1, 1);
        check_eq("alt_0", 32'(disp_score), 32'(exp_seq[0]));
        for (int i = 1; i < 9; i++) begin
            step(0, i[0], i[1], 1);
            check_eq($sformatf("alt_%0d", i), 32'(disp_score), 32'(exp_seq[i]));
        end
        check_eq("alt_score", 32'(score), 32'd2);

        // Restart in PLAY.
        step(0, 0, 0, 0);
        step(1, 0, 0, 1); oks(3); step(0, 0, 1, 1);
        step(1, 0, 0, 1); oks(7);
        step(1, 0, 0, 1);
        check_eq("rs_score", 32'(score), 32'd0);
        check_eq("rs_high", 32'(high_score), 32'd3);
        check_eq("rs_playing", 32'(playing), 32'd1);
        check_eq("rs_rec", 32'(new_record), 32'd0);

        // Mid-game reset.
        step(0, 0, 0, 0);
        step(1, 0, 0, 1); oks(20); step(0, 0, 1, 1);
        step(1, 0, 0, 1); oks(10);
        step(0, 1, 0, 0);
        check_eq("mr_score", 32'(score), 32'd0);
        check_eq("mr_high", 32'(high_score), 32'd0);
        check_eq("mr_disp", 32'(disp_score), 32'd0);
        check_eq("mr_playing", 32'(playing), 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            bit rn, ng, ok, go;
            rn = ($urandom_range(0, 299) != 0);
            ng = ($urandom_range(0, 49) == 0);
            ok = ($urandom_range(0, 3) != 0);
            go = ($urandom_range(0, 24) == 0);
            step(ng, ok, go, rn);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
